alu_operand_loader: RTL and testbench

Byte-serial command loader sitting directly upstream of the arithmetic logic unit. Accepts an opcode byte and one or two operand bytes over an 8-bit valid/ready input stream. Assembles them into a complete ALU command and presents it to the ALU through a valid/ready handshake. Illegal opcodes are rejected and reported; stalled partial commands are optionally timed out.

---
 rtl/alu_loader_pkg.sv | 43 ++++
 rtl/alu_operand_loader_if.sv | 39 +++
 rtl/alu_loader_timeout.sv | 36 +++
 rtl/alu_operand_loader.sv | 192 +++++++++++++++++++
 tb/tb_alu_operand_loader.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_loader_pkg.sv
// Shared types for the ALU operand loader: opcode map, FSM states and opcode
// classification helpers.
package alu_loader_pkg;

  localparam int unsigned PKG_OPC_W = 4;

  typedef enum logic [PKG_OPC_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_CMP = 4'd8,
    OP_MUL = 4'd9
  } alu_opcode_e;

  // First opcode value outside the map; everything from here up is rejected.
  localparam logic [PKG_OPC_W-1:0] OPC_ILLEGAL_MIN = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_A = 2'd1,
    GET_B = 2'd2,
    ISSUE = 2'd3
  } loader_state_e;

  function automatic logic is_unary(input logic [PKG_OPC_W-1:0] op);
    logic unary;
    case (op)
      OP_NOT, OP_SHL, OP_SHR: unary = 1'b1;
      default:                unary = 1'b0;
    endcase
    return unary;
  endfunction

  function automatic logic is_legal(input logic [PKG_OPC_W-1:0] op);
    return (op < OPC_ILLEGAL_MIN);
  endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Byte-stream input and ALU command output bundle of the operand loader.
// slave: the loader side; master: the upstream source / ALU side.
interface alu_operand_loader_if #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              alu_valid;
  logic              alu_ready;
  logic [OPC_W-1:0]  alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output alu_valid,
    input  alu_ready,
    output alu_op,
    output alu_a,
    output alu_b
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  alu_valid,
    output alu_ready,
    input  alu_op,
    input  alu_a,
    input  alu_b
  );

endinterface

// File: rtl/alu_loader_timeout.sv
// Idle-cycle counter for partial commands; expire asserts on the cycle the
// count would reach TIMEOUT_CYC without being cleared.
module alu_loader_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             expire_s;

  // A clear in the same cycle (byte accepted) always beats expiry.
  assign expire_s = en & ~clr & (cnt_r == CNT_LAST);
  assign expire   = expire_s;

  // Idle counter: clears on accept or expiry, counts while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr || expire_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Byte-serial ALU command loader: opcode byte then one or two operand bytes,
// issued as one command. Optional partial-command timeout: ALU_LOADER_TIMEOUT_EN.
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OPC_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_loader_if.slave  bus,
  output logic                 busy,
  output logic                 err_opcode,
  output logic                 err_timeout,
  output logic [7:0]           cmd_count
);

  loader_state_e     state_r;
  loader_state_e     next_state_s;

  logic              in_ready_r;
  logic              alu_valid_r;
  logic              busy_r;
  logic              err_opcode_r;
  logic              err_timeout_r;
  logic [OPC_W-1:0]  alu_op_r;
  logic [DATA_W-1:0] alu_a_r;
  logic [DATA_W-1:0] alu_b_r;
  logic [7:0]        cmd_count_r;

  logic                 accept_s;
  logic [OPC_W-1:0]     opc_s;
  logic [PKG_OPC_W-1:0] opc_in_s;
  logic [PKG_OPC_W-1:0] opc_cur_s;
  logic                 wait_state_s;
  logic                 timeout_s;
  logic                 ld_op_s;
  logic                 ld_a_s;
  logic                 ld_b_s;
  logic                 clr_b_s;
  logic                 err_op_s;
  logic                 err_to_s;
  logic                 issue_done_s;

  assign accept_s     = bus.in_valid & in_ready_r;
  assign opc_s        = bus.in_data[OPC_W-1:0];
  assign opc_in_s     = PKG_OPC_W'(opc_s);
  assign opc_cur_s    = PKG_OPC_W'(alu_op_r);
  assign wait_state_s = (state_r == GET_A) || (state_r == GET_B);

`ifdef ALU_LOADER_TIMEOUT_EN
  alu_loader_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept_s | ~wait_state_s),
    .en     (wait_state_s),
    .expire (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and datapath load strobes.
  always_comb begin
    next_state_s = state_r;
    ld_op_s      = 1'b0;
    ld_a_s       = 1'b0;
    ld_b_s       = 1'b0;
    clr_b_s      = 1'b0;
    err_op_s     = 1'b0;
    err_to_s     = 1'b0;
    issue_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (is_legal(opc_in_s)) begin
            next_state_s = GET_A;
            ld_op_s      = 1'b1;
          end else begin
            err_op_s     = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      GET_A: begin
        if (accept_s) begin
          ld_a_s = 1'b1;
          if (is_unary(opc_cur_s)) begin
            next_state_s = ISSUE;
            clr_b_s      = 1'b1;
          end else begin
            next_state_s = GET_B;
          end
        end else if (timeout_s) begin
          next_state_s = IDLE;
          err_to_s     = 1'b1;
        end else begin
          next_state_s = GET_A;
        end
      end
      GET_B: begin
        if (accept_s) begin
          ld_b_s       = 1'b1;
          next_state_s = ISSUE;
        end else if (timeout_s) begin
          next_state_s = IDLE;
          err_to_s     = 1'b1;
        end else begin
          next_state_s = GET_B;
        end
      end
      ISSUE: begin
        if (bus.alu_ready) begin
          next_state_s = IDLE;
          issue_done_s = 1'b1;
        end else begin
          next_state_s = ISSUE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Handshake and status flags, registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r    <= 1'b0;
      alu_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      err_opcode_r  <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      in_ready_r    <= (next_state_s != ISSUE);
      alu_valid_r   <= (next_state_s == ISSUE);
      busy_r        <= (next_state_s != IDLE);
      err_opcode_r  <= err_op_s;
      err_timeout_r <= err_to_s;
    end
  end

  // Command fields and issued-command counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_r    <= {OPC_W{1'b0}};
      alu_a_r     <= {DATA_W{1'b0}};
      alu_b_r     <= {DATA_W{1'b0}};
      cmd_count_r <= 8'd0;
    end else begin
      if (ld_op_s) begin
        alu_op_r <= opc_s;
      end
      if (ld_a_s) begin
        alu_a_r <= bus.in_data;
      end
      if (ld_b_s) begin
        alu_b_r <= bus.in_data;
      end else if (clr_b_s) begin
        alu_b_r <= {DATA_W{1'b0}};
      end
      if (issue_done_s) begin
        cmd_count_r <= cmd_count_r + 8'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.alu_valid = alu_valid_r;
  assign bus.alu_op    = alu_op_r;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign busy          = busy_r;
  assign err_opcode    = err_opcode_r;
  assign err_timeout   = err_timeout_r;
  assign cmd_count     = cmd_count_r;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: vector table plus scoreboard,
// with hand sequences for backpressure, reset, wrap-around and timeout.
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic       err_opcode;
  logic       err_timeout;
  logic [7:0] cmd_count;

  always #5 clk = ~clk;

  alu_operand_loader_if #(.DATA_W(8), .OPC_W(4)) bus_if ();

  alu_operand_loader #(
    .DATA_W      (8),
    .OPC_W       (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .busy        (busy),
    .err_opcode  (err_opcode),
    .err_timeout (err_timeout),
    .cmd_count   (cmd_count)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef struct {
    logic [7:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic       legal;
    logic       unary;
    logic [3:0] exp_op;
    logic [7:0] exp_b;
  } vec_t;

  cmd_t       exp_q[$];
  int         hs_cyc_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_count;
  logic [3:0] last_op;
  logic [7:0] last_a;
  logic [7:0] last_b;
  cmd_t       mon_e;
  vec_t       tbl[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a handshake will happen on the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus_if.alu_valid === 1'b1 && bus_if.alu_ready === 1'b1) begin
      hs_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: actual op=%0h a=%0h b=%0h expected none",
                 bus_if.alu_op, bus_if.alu_a, bus_if.alu_b);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_op", 32'(bus_if.alu_op), 32'(mon_e.op));
        chk("sb_a",  32'(bus_if.alu_a),  32'(mon_e.a));
        chk("sb_b",  32'(bus_if.alu_b),  32'(mon_e.b));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = b;
    while (bus_if.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: actual=never-ready expected=ready within 50 cycles");
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic expect_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_t c;
    c.op = op;
    c.a  = a;
    c.b  = b;
    exp_q.push_back(c);
    exp_count = exp_count + 8'd1;
    last_op = op;
    last_a  = a;
    last_b  = b;
  endtask

  task automatic run_vec(input vec_t v);
    if (!v.legal) begin
      send_byte(v.opc);
      chk("ill_err_pulse", 32'(err_opcode), 32'(1));
      chk("ill_busy",      32'(busy), 32'(0));
      chk("ill_in_ready",  32'(bus_if.in_ready), 32'(1));
      chk("ill_op_keep",   32'(bus_if.alu_op), 32'(last_op));
      chk("ill_a_keep",    32'(bus_if.alu_a), 32'(last_a));
      chk("ill_b_keep",    32'(bus_if.alu_b), 32'(last_b));
      chk("ill_count",     32'(cmd_count), 32'(exp_count));
      @(posedge clk); #1;
      chk("ill_err_clear", 32'(err_opcode), 32'(0));
    end else begin
      expect_cmd(v.exp_op, v.a, v.exp_b);
      send_byte(v.opc);
      send_byte(v.a);
      if (!v.unary) send_byte(v.b);
      chk("cmd_valid",    32'(bus_if.alu_valid), 32'(1));
      chk("cmd_in_ready", 32'(bus_if.in_ready), 32'(0));
      chk("cmd_busy",     32'(busy), 32'(1));
      @(posedge clk); #1;
      chk("hs_valid_low", 32'(bus_if.alu_valid), 32'(0));
      chk("hs_in_ready",  32'(bus_if.in_ready), 32'(1));
      chk("hs_busy",      32'(busy), 32'(0));
      chk("hs_count",     32'(cmd_count), 32'(exp_count));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int bad_gap;
    vec_t v;
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'h00;
    bus_if.alu_ready = 1'b0;
    exp_count = 8'd0;
    last_op = 4'h0;
    last_a  = 8'h00;
    last_b  = 8'h00;

    tbl[0]  = '{8'h00, 8'h12, 8'h34, 1'b1, 1'b0, 4'h0, 8'h34};
    tbl[1]  = '{8'h01, 8'h80, 8'h01, 1'b1, 1'b0, 4'h1, 8'h01};
    tbl[2]  = '{8'h0C, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00};
    tbl[3]  = '{8'h02, 8'hF0, 8'h0F, 1'b1, 1'b0, 4'h2, 8'h0F};
    tbl[4]  = '{8'h03, 8'hAA, 8'h55, 1'b1, 1'b0, 4'h3, 8'h55};
    tbl[5]  = '{8'h04, 8'hFF, 8'h0F, 1'b1, 1'b0, 4'h4, 8'h0F};
    tbl[6]  = '{8'h05, 8'hA5, 8'h77, 1'b1, 1'b1, 4'h5, 8'h00};
    tbl[7]  = '{8'h06, 8'h81, 8'h00, 1'b1, 1'b1, 4'h6, 8'h00};
    tbl[8]  = '{8'h07, 8'h7E, 8'h00, 1'b1, 1'b1, 4'h7, 8'h00};
    tbl[9]  = '{8'h08, 8'h10, 8'h20, 1'b1, 1'b0, 4'h8, 8'h20};
    tbl[10] = '{8'h09, 8'h0F, 8'h0F, 1'b1, 1'b0, 4'h9, 8'h0F};
    tbl[11] = '{8'h0A, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00};
    tbl[12] = '{8'h1F, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00};
    tbl[13] = '{8'hF3, 8'hC3, 8'h3C, 1'b1, 1'b0, 4'h3, 8'h3C};
    tbl[14] = '{8'h0B, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00};
    tbl[15] = '{8'h95, 8'h01, 8'hEE, 1'b1, 1'b1, 4'h5, 8'h00};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",    32'(bus_if.in_ready), 32'(0));
    chk("rst_alu_valid",   32'(bus_if.alu_valid), 32'(0));
    chk("rst_alu_op",      32'(bus_if.alu_op), 32'(0));
    chk("rst_alu_a",       32'(bus_if.alu_a), 32'(0));
    chk("rst_alu_b",       32'(bus_if.alu_b), 32'(0));
    chk("rst_busy",        32'(busy), 32'(0));
    chk("rst_err_opcode",  32'(err_opcode), 32'(0));
    chk("rst_err_timeout", 32'(err_timeout), 32'(0));
    chk("rst_cmd_count",   32'(cmd_count), 32'(0));
    rst = 1'b0;
    #1;
    chk("rel_in_ready_low", 32'(bus_if.in_ready), 32'(0));
    @(posedge clk); #1;
    chk("rel_in_ready_high", 32'(bus_if.in_ready), 32'(1));

    // Vector table
    bus_if.alu_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = tbl[i];
      run_vec(v);
    end

    // Unary command held under backpressure
    bus_if.alu_ready = 1'b0;
    expect_cmd(4'h5, 8'hA5, 8'h00);
    send_byte(8'h05);
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid",    32'(bus_if.alu_valid), 32'(1));
      chk("bp_in_ready", 32'(bus_if.in_ready), 32'(0));
      chk("bp_op",       32'(bus_if.alu_op), 32'(5));
      chk("bp_a",        32'(bus_if.alu_a), 32'(8'hA5));
      chk("bp_b",        32'(bus_if.alu_b), 32'(0));
      chk("bp_count",    32'(cmd_count), 32'(exp_count - 8'd1));
      @(posedge clk); #1;
    end
    bus_if.alu_ready = 1'b1;
    chk("bp_valid_before_hs", 32'(bus_if.alu_valid), 32'(1));
    @(posedge clk); #1;
    chk("bp_hs_valid_low", 32'(bus_if.alu_valid), 32'(0));
    chk("bp_hs_in_ready",  32'(bus_if.in_ready), 32'(1));
    chk("bp_hs_count",     32'(cmd_count), 32'(exp_count));

`ifdef ALU_LOADER_TIMEOUT_EN
    // Stalled partial command times out after 8 idle cycles
    send_byte(8'h01);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      chk("to_no_pulse_yet", 32'(err_timeout), 32'(0));
      chk("to_busy",         32'(busy), 32'(1));
    end
    @(posedge clk); #1;
    chk("to_pulse",    32'(err_timeout), 32'(1));
    chk("to_idle",     32'(busy), 32'(0));
    chk("to_in_ready", 32'(bus_if.in_ready), 32'(1));
    chk("to_count",    32'(cmd_count), 32'(exp_count));
    @(posedge clk); #1;
    chk("to_pulse_end", 32'(err_timeout), 32'(0));
    // Byte accepted on the expiry cycle wins
    expect_cmd(4'h1, 8'h3C, 8'hC3);
    send_byte(8'h01);
    repeat (7) @(posedge clk);
    #1;
    send_byte(8'h3C);
    chk("to_race_no_err", 32'(err_timeout), 32'(0));
    chk("to_race_busy",   32'(busy), 32'(1));
    send_byte(8'hC3);
    chk("to_race_valid", 32'(bus_if.alu_valid), 32'(1));
    @(posedge clk); #1;
    chk("to_race_count", 32'(cmd_count), 32'(exp_count));
`else
    // Without the timeout a partial command waits indefinitely
    expect_cmd(4'h1, 8'h3C, 8'hC3);
    send_byte(8'h01);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("nto_no_pulse", 32'(err_timeout), 32'(0));
      chk("nto_busy",     32'(busy), 32'(1));
    end
    send_byte(8'h3C);
    send_byte(8'hC3);
    chk("nto_valid", 32'(bus_if.alu_valid), 32'(1));
    @(posedge clk); #1;
    chk("nto_count", 32'(cmd_count), 32'(exp_count));
`endif

    // Reset in the middle of a command
    send_byte(8'h00);
    send_byte(8'h12);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",  32'(bus_if.in_ready), 32'(0));
    chk("mid_rst_valid",     32'(bus_if.alu_valid), 32'(0));
    chk("mid_rst_op",        32'(bus_if.alu_op), 32'(0));
    chk("mid_rst_a",         32'(bus_if.alu_a), 32'(0));
    chk("mid_rst_b",         32'(bus_if.alu_b), 32'(0));
    chk("mid_rst_busy",      32'(busy), 32'(0));
    chk("mid_rst_count",     32'(cmd_count), 32'(0));
    exp_count = 8'd0;
    last_op = 4'h0;
    last_a  = 8'h00;
    last_b  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus_if.in_ready), 32'(1));
    v = '{8'h00, 8'h55, 8'h66, 1'b1, 1'b0, 4'h0, 8'h66};
    run_vec(v);

    // 256 back-to-back ADDs from a clean reset: counter wraps, 4-cycle period
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = 8'd0;
    @(posedge clk); #1;
    hs_cyc_q.delete();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ib;
      ib = 8'(i);
      expect_cmd(4'h0, ib, ~ib);
      send_byte(8'h00);
      send_byte(ib);
      send_byte(~ib);
    end
    @(posedge clk); #1;
    chk("wrap_count",    32'(cmd_count), 32'(0));
    chk("wrap_hs_total", 32'(hs_cyc_q.size()), 32'(256));
    if (hs_cyc_q.size() == 256) begin
      bad_gap = 0;
      for (int i = 1; i < 256; i++) begin
        if (hs_cyc_q[i] - hs_cyc_q[i-1] != 4) bad_gap++;
      end
      chk("wrap_period_gaps", 32'(bad_gap), 32'(0));
    end

    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
